// File: rtl/gpu_block_dispatcher_pkg.sv
// Shared types and helpers for the GPU block dispatcher: FSM encodings,
// block-count arithmetic and parameter legality.
package gpu_dispatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_DONE     = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        C_FREE  = 2'd0,
        C_RESET = 2'd1,
        C_RUN   = 2'd2
    } core_state_t;

    // One extra bit of headroom so the round-up never overflows
    function automatic logic [32:0] ceil_blocks(input logic [31:0] tc, input int tpb);
        logic [32:0] sum;
        sum = {1'b0, tc} + 33'(tpb - 1);
        return sum >> $clog2(tpb);
    endfunction

    function automatic bit params_legal(input int nc, input int tpb, input int tcb, input int bib);
        return (nc >= 1) && (nc <= 16) && (tpb >= 1) && ((tpb & (tpb - 1)) == 0) &&
               (tcb >= 1) && (tcb <= 32) && (bib >= tcb - $clog2(tpb));
    endfunction

endpackage

// File: rtl/gpu_block_dispatcher_rr_picker.sv
// Combinational round-robin search: first set bit of a free mask at or
// after a pointer, wrapping around, plus a found flag.
module dispatch_rr_picker #(
    parameter int NUM_CORES = 2,
    parameter int PW        = 1
) (
    input  logic [NUM_CORES-1:0] i_free_mask,
    input  logic [PW-1:0]        i_ptr,
    output logic [PW-1:0]        o_idx,
    output logic                 o_found
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!o_found && i_free_mask[i] && (PW'(i) >= i_ptr)) begin
                o_found = 1'b1;
                o_idx   = PW'(i);
            end
        end
        // Wrap-around pass covers the cores below the pointer
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!o_found && i_free_mask[i]) begin
                o_found = 1'b1;
                o_idx   = PW'(i);
            end
        end
    end

endmodule

// File: rtl/gpu_block_dispatcher.sv
// Splits a kernel launch into fixed-size thread blocks and hands them
// round-robin to free compute cores, tracking each core's reset/run lifecycle.
module gpu_block_dispatcher
    import gpu_dispatch_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int BLOCK_ID_BITS     = 8,
    localparam int TC_BITS          = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [THREAD_COUNT_BITS-1:0]       thread_count,
    input  logic [NUM_CORES-1:0]               core_done,
    output logic [NUM_CORES-1:0]               core_reset,
    output logic [NUM_CORES-1:0]               core_start,
    output logic [NUM_CORES*BLOCK_ID_BITS-1:0] core_block_id,
    output logic [NUM_CORES*TC_BITS-1:0]       core_thread_count,
    output logic                               busy,
    output logic                               done
);

    localparam int LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int CW       = THREAD_COUNT_BITS + 1;
    localparam int PW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int RW       = CW + LOG2_TPB + 1;

    if (!params_legal(NUM_CORES, THREADS_PER_BLOCK, THREAD_COUNT_BITS, BLOCK_ID_BITS)) begin : g_bad_params
        $error("gpu_block_dispatcher: illegal parameter combination");
    end

    top_state_t                   r_state, w_state_nxt;
    logic [THREAD_COUNT_BITS-1:0] r_tc;
    logic [CW-1:0]                r_total, r_next_block, r_blocks_done;
    logic [PW-1:0]                r_rr_ptr;
    core_state_t                  r_cstate [NUM_CORES];
    logic [BLOCK_ID_BITS-1:0]     r_bid    [NUM_CORES];
    logic [TC_BITS-1:0]           r_cnt    [NUM_CORES];

    logic [NUM_CORES-1:0] w_free_mask, w_retire;
    logic [CW-1:0]        w_retire_cnt, w_done_sum, w_total_new;
    logic [PW-1:0]        w_pick_idx, w_rr_nxt;
    logic                 w_pick_found, w_assign;
    logic [RW-1:0]        w_remain;
    logic [TC_BITS-1:0]   w_blk_cnt;

    dispatch_rr_picker #(.NUM_CORES(NUM_CORES), .PW(PW)) u_picker (
        .i_free_mask (w_free_mask),
        .i_ptr       (r_rr_ptr),
        .o_idx       (w_pick_idx),
        .o_found     (w_pick_found)
    );

    always_comb begin
        w_retire_cnt = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_free_mask[k] = (r_cstate[k] == C_FREE);
            w_retire[k]    = (r_cstate[k] == C_RUN) && core_done[k];
            w_retire_cnt   = w_retire_cnt + CW'(w_retire[k]);
        end
        w_done_sum  = r_blocks_done + w_retire_cnt;
        w_total_new = CW'(ceil_blocks(32'(thread_count), THREADS_PER_BLOCK));
        w_assign    = (r_state == S_DISPATCH) && (r_next_block < r_total) && w_pick_found;
        w_rr_nxt    = (w_pick_idx == PW'(NUM_CORES - 1)) ? '0 : w_pick_idx + 1'b1;
        // Threads left from this block onward; only the last block can be short
        w_remain    = RW'(r_tc) - (RW'(r_next_block) << LOG2_TPB);
        w_blk_cnt   = (w_remain >= RW'(THREADS_PER_BLOCK)) ? TC_BITS'(THREADS_PER_BLOCK)
                                                           : TC_BITS'(w_remain);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = (w_total_new == '0) ? S_DONE : S_DISPATCH;
            S_DISPATCH: if (w_done_sum == r_total) w_state_nxt = S_DONE;
            S_DONE:     if (!start) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tc          <= '0;
            r_total       <= '0;
            r_next_block  <= '0;
            r_blocks_done <= '0;
            r_rr_ptr      <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                r_cstate[k] <= C_FREE;
                r_bid[k]    <= '0;
                r_cnt[k]    <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_tc          <= thread_count;
                r_total       <= w_total_new;
                r_next_block  <= '0;
                r_blocks_done <= '0;
            end
            if (r_state == S_DISPATCH) r_blocks_done <= w_done_sum;
            if (w_assign) begin
                r_next_block <= r_next_block + 1'b1;
                r_rr_ptr     <= w_rr_nxt;
            end
            for (int k = 0; k < NUM_CORES; k++) begin
                case (r_cstate[k])
                    C_FREE: if (w_assign && w_pick_idx == PW'(k)) begin
                        r_cstate[k] <= C_RESET;
                        r_bid[k]    <= BLOCK_ID_BITS'(r_next_block);
                        r_cnt[k]    <= w_blk_cnt;
                    end
                    C_RESET: r_cstate[k] <= C_RUN;
                    C_RUN:   if (core_done[k]) r_cstate[k] <= C_FREE;
                    default: r_cstate[k] <= C_FREE;
                endcase
            end
        end
    end

    always_comb begin
        busy              = (r_state == S_DISPATCH);
        done              = (r_state == S_DONE);
        core_block_id     = '0;
        core_thread_count = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            core_reset[k] = (r_cstate[k] == C_RESET);
            core_start[k] = (r_cstate[k] == C_RUN);
            core_block_id[k*BLOCK_ID_BITS +: BLOCK_ID_BITS] = r_bid[k];
            core_thread_count[k*TC_BITS +: TC_BITS]         = r_cnt[k];
        end
    end

endmodule

// File: tb/tb_gpu_block_dispatcher.sv
// Directed bench for gpu_block_dispatcher: three configurations (2 cores/TPB 4,
// 4 cores/TPB 1, and a wide 16-bit launch) checked with hand-derived values.
module tb_gpu_block_dispatcher;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Config A: 2 cores, 4 threads per block
    logic        a_start, a_busy, a_dn;
    logic [7:0]  a_tc;
    logic [1:0]  a_done, a_rst, a_st;
    logic [15:0] a_bid;
    logic [5:0]  a_cnt;

    // Config B: 4 cores, 1 thread per block
    logic        b_start, b_busy, b_dn;
    logic [7:0]  b_tc;
    logic [3:0]  b_done, b_rst, b_st;
    logic [31:0] b_bid;
    logic [3:0]  b_cnt;

    // Config C: wide thread count, 32 threads per block
    logic        c_start, c_busy, c_dn;
    logic [15:0] c_tc;
    logic [1:0]  c_done, c_rst, c_st;
    logic [21:0] c_bid;
    logic [11:0] c_cnt;

    gpu_block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(4), .THREAD_COUNT_BITS(8), .BLOCK_ID_BITS(8)) u_a (
        .clk(clk), .reset(reset), .start(a_start), .thread_count(a_tc), .core_done(a_done),
        .core_reset(a_rst), .core_start(a_st), .core_block_id(a_bid), .core_thread_count(a_cnt),
        .busy(a_busy), .done(a_dn)
    );

    gpu_block_dispatcher #(.NUM_CORES(4), .THREADS_PER_BLOCK(1), .THREAD_COUNT_BITS(8), .BLOCK_ID_BITS(8)) u_b (
        .clk(clk), .reset(reset), .start(b_start), .thread_count(b_tc), .core_done(b_done),
        .core_reset(b_rst), .core_start(b_st), .core_block_id(b_bid), .core_thread_count(b_cnt),
        .busy(b_busy), .done(b_dn)
    );

    gpu_block_dispatcher #(.NUM_CORES(2), .THREADS_PER_BLOCK(32), .THREAD_COUNT_BITS(16), .BLOCK_ID_BITS(11)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .thread_count(c_tc), .core_done(c_done),
        .core_reset(c_rst), .core_start(c_st), .core_block_id(c_bid), .core_thread_count(c_cnt),
        .busy(c_busy), .done(c_dn)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    int          n_assign;
    logic [10:0] last_bid;
    logic [5:0]  last_cnt;

    initial begin
        reset = 1'b1;
        a_start = 0; a_tc = 0; a_done = 0;
        b_start = 0; b_tc = 0; b_done = 0;
        c_start = 0; c_tc = 0; c_done = 0;
        step(2);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_dn, 0);
        check("rst_core_reset", a_rst, 0);
        check("rst_core_start", a_st, 0);
        check("rst_bid", a_bid, 0);
        check("rst_cnt", a_cnt, 0);
        reset = 1'b0;
        step(1);

        // Partial last block: 10 threads -> 4,4,2
        a_tc = 8'd10; a_start = 1;
        step(1);
        check("p_busy", a_busy, 1);
        check("p_no_rst_yet", a_rst, 0);
        a_start = 0; a_tc = 8'hff;
        step(1);
        check("p_rst0", a_rst, 2'b01);
        check("p_bid0", a_bid[7:0], 0);
        check("p_cnt0", a_cnt[2:0], 4);
        step(1);
        check("p_rst1", a_rst, 2'b10);
        check("p_st0", a_st, 2'b01);
        check("p_bid1", a_bid[15:8], 1);
        check("p_cnt1", a_cnt[5:3], 4);
        step(1);
        check("p_st_both", a_st, 2'b11);
        check("p_rst_idle", a_rst, 0);
        a_done = 2'b10;
        step(1);
        check("p_st_after_retire", a_st, 2'b01);
        a_done = 2'b00;
        step(1);
        check("p_rst2", a_rst, 2'b10);
        check("p_bid2", a_bid[15:8], 2);
        check("p_cnt2", a_cnt[5:3], 2);
        check("p_busy_mid", a_busy, 1);
        step(1);
        check("p_st_both2", a_st, 2'b11);
        a_done = 2'b11;
        step(1);
        check("p_done", a_dn, 1);
        check("p_busy_end", a_busy, 0);
        check("p_st_end", a_st, 0);
        a_done = 2'b00;
        check("p_bid_hold", a_bid, 16'h0200);
        step(1);
        check("p_idle", a_dn, 0);

        // Zero threads
        a_tc = 8'd0; a_start = 1;
        step(1);
        check("z_done", a_dn, 1);
        check("z_busy", a_busy, 0);
        step(3);
        check("z_done_hold", a_dn, 1);
        check("z_no_rst", a_rst, 0);
        check("z_no_st", a_st, 0);
        a_start = 0;
        step(1);
        check("z_idle", a_dn, 0);

        // Exact multiple: 8 threads
        a_tc = 8'd8; a_start = 1;
        step(1);
        check("e_busy", a_busy, 1);
        a_start = 0;
        step(1);
        check("e_rst0", a_rst, 2'b01);
        step(1);
        check("e_rst1", a_rst, 2'b10);
        step(1);
        check("e_rst_off", a_rst, 0);
        check("e_st", a_st, 2'b11);
        a_done = 2'b11;
        step(1);
        check("e_done", a_dn, 1);
        check("e_busy_end", a_busy, 0);
        a_done = 2'b00;
        step(1);
        check("e_idle", a_dn, 0);

        // Reset while both cores run, then relaunch with 5 threads
        a_tc = 8'd8; a_start = 1;
        step(1);
        a_start = 0;
        step(3);
        check("r_running", a_st, 2'b11);
        reset = 1'b1;
        step(1);
        check("r_st", a_st, 0);
        check("r_rst", a_rst, 0);
        check("r_busy", a_busy, 0);
        check("r_done", a_dn, 0);
        check("r_bid", a_bid, 0);
        check("r_cnt", a_cnt, 0);
        reset = 1'b0; a_tc = 8'd5; a_start = 1;
        step(1);
        check("r2_busy", a_busy, 1);
        a_start = 0;
        step(1);
        check("r2_rst0", a_rst, 2'b01);
        check("r2_cnt0", a_cnt[2:0], 4);
        step(1);
        check("r2_rst1", a_rst, 2'b10);
        check("r2_bid1", a_bid[15:8], 1);
        check("r2_cnt1", a_cnt[5:3], 1);
        step(1);
        check("r2_st", a_st, 2'b11);
        a_done = 2'b11;
        step(1);
        check("r2_done", a_dn, 1);
        a_done = 2'b00;
        step(1);
        check("r2_idle", a_dn, 0);

        // Simultaneous retirement on 4 cores, 6 single-thread blocks
        b_tc = 8'd6; b_start = 1;
        step(1);
        b_start = 0;
        step(4);
        check("s_rst3", b_rst, 4'b1000);
        check("s_st012", b_st, 4'b0111);
        step(1);
        check("s_st_all", b_st, 4'b1111);
        b_done = 4'b1111;
        step(1);
        check("s_st_off", b_st, 0);
        check("s_rst_off", b_rst, 0);
        check("s_busy", b_busy, 1);
        check("s_not_done", b_dn, 0);
        b_done = 4'b0000;
        step(1);
        check("s_rst_c0", b_rst, 4'b0001);
        check("s_bid4", b_bid[7:0], 4);
        step(1);
        check("s_rst_c1", b_rst, 4'b0010);
        check("s_bid5", b_bid[15:8], 5);
        check("s_bid_all", b_bid, 32'h03020504);
        check("s_cnt_all", b_cnt, 4'b1111);
        step(1);
        check("s_st01", b_st, 4'b0011);
        b_done = 4'b0011;
        step(1);
        check("s_done", b_dn, 1);
        check("s_busy_end", b_busy, 0);
        b_done = 4'b0000;
        step(1);
        check("s_idle", b_dn, 0);

        // Wide launch: 65535 threads in blocks of 32
        n_assign = 0; last_bid = '0; last_cnt = '0;
        c_tc = 16'hffff; c_start = 1;
        step(1);
        c_start = 0;
        check("w_busy", c_busy, 1);
        for (int i = 0; i < 20000 && !c_dn; i++) begin
            c_done = c_st;
            step(1);
            for (int k = 0; k < 2; k++) begin
                if (c_rst[k]) begin
                    n_assign++;
                    last_bid = c_bid[k*11 +: 11];
                    last_cnt = c_cnt[k*6 +: 6];
                end
            end
        end
        c_done = 2'b00;
        check("w_done", c_dn, 1);
        check("w_nblocks", n_assign, 2048);
        check("w_last_bid", last_bid, 2047);
        check("w_last_cnt", last_cnt, 31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpu_block_dispatcher.md
Name: gpu_block_dispatcher

Overview:
Parametrised successor to the GPU's block dispatch logic. It splits a kernel launch of thread_count threads into blocks of THREADS_PER_BLOCK threads and hands blocks to free compute cores round-robin. Each core runs a reset/start/done lifecycle. Supports wide thread counts, a partial last block, and several cores retiring in the same cycle. Sits between the device control register and the core array.

Parameters:
NUM_CORES, 2, number of compute cores served (1..16)
THREADS_PER_BLOCK, 4, threads per block; power of two, >=1
THREAD_COUNT_BITS, 8, width of thread_count
BLOCK_ID_BITS, 8, width of each block id; elaboration error if < THREAD_COUNT_BITS - log2(THREADS_PER_BLOCK)
TC_BITS (local), $clog2(THREADS_PER_BLOCK)+1, width of per-core thread count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
start  in  1  kernel launch request (level)
thread_count  in  THREAD_COUNT_BITS  total threads, sampled on launch
core_done  in  NUM_CORES  per-core block completion
core_reset  out  NUM_CORES  per-core one-cycle reset pulse
core_start  out  NUM_CORES  per-core run enable
core_block_id  out  NUM_CORES*BLOCK_ID_BITS  flattened; core k at [k*BLOCK_ID_BITS +: BLOCK_ID_BITS]
core_thread_count  out  NUM_CORES*TC_BITS  flattened threads for core k's block
busy  out  1  kernel in progress
done  out  1  kernel complete

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. On reset, all outputs are 0, all counters are 0, top FSM goes to IDLE, every core goes to C_FREE, and the round-robin pointer is 0. A reset mid-kernel abandons the kernel; no done is produced.
- Latched totals: total_blocks = (thread_count + TPB - 1) >> log2(TPB), computed at THREAD_COUNT_BITS+1 width so there is no overflow.
- Counters: next_block, blocks_done; each is THREAD_COUNT_BITS+1 wide.
- Top FSM: IDLE, DISPATCH, DONE.
  - IDLE: if start=1, latch thread_count and total_blocks and clear the counters. If total_blocks=0, go to DONE; otherwise go to DISPATCH.
  - DISPATCH: busy=1. Go to DONE on the edge where blocks_done (including this cycle's retirements) equals total_blocks.
  - DONE: done=1, busy=0. Hold until start=0, then go to IDLE. If start is still high, no relaunch occurs.
- Per-core FSM: C_FREE, C_RESET, C_RUN.
  - Assignment: in DISPATCH with next_block < total_blocks, at most one block is assigned per cycle. It goes to the first C_FREE core searching from rr_ptr upward with wrap. rr_ptr then becomes the chosen core + 1 (mod NUM_CORES).
  - On assignment: core_block_id[k] = next_block (truncated to BLOCK_ID_BITS), and core_thread_count[k] = min(TPB, thread_count - next_block*TPB). next_block increments and the core goes to C_RESET.
  - C_RESET: core_reset[k]=1 for exactly one cycle, then C_RUN.
  - C_RUN: core_start[k]=1. core_done[k]=1 sampled in C_RUN retires the block: the core goes to C_FREE and core_start drops the next cycle. core_done is ignored in any other state.
  - A core freed at an edge is eligible for assignment from the following edge (one-cycle gap).
  - core_block_id and core_thread_count hold their values until the core is next assigned.
- Simultaneous retirement: blocks_done += popcount(retiring cores) in one cycle.
- Latency: start sampled at edge N puts DISPATCH in effect after edge N. The first assignment happens at edge N+1 (core_reset visible). core_start rises after edge N+2.
- Inputs during DISPATCH: start and thread_count changes are ignored.
- Registering: all outputs are registered; there is no combinational path from input to output.

Decomposition:
- Package gpu_dispatch_pkg holds:
  - the top and core state enums;
  - function ceil_blocks(thread_count, TPB);
  - the parameter legality checks.
- Natural sub-module: dispatch_rr_picker. It is combinational and returns the first set bit of a free mask at or after a pointer, plus a found flag. It is instantiated once.

Test Plan:
- Reset mid-run: reset for 1 cycle while 2 cores are in C_RUN -> next cycle all outputs are 0, FSM is IDLE, and a later start relaunches cleanly.
- Partial last block: NUM_CORES=2, TPB=4, thread_count=10 -> blocks 0,1,2 with thread counts 4,4,2. Block 2 goes to the first freed core after rr_ptr. done rises after the third core_done.
- Zero threads: thread_count=0, start=1 -> no core_reset or core_start ever. done=1 one cycle after the start edge, and stays 1 until start=0.
- Exact multiple: thread_count=8, cores return done 5 cycles after start -> core_reset[0] and core_reset[1] pulse on consecutive cycles, each 1 cycle wide. done=1 with busy=0 after both retire.
- Simultaneous done: NUM_CORES=4, TPB=1, thread_count=6, all four cores assert core_done in the same cycle -> blocks_done jumps 0->4. Blocks 4 and 5 go to cores 0 and 1 on the next two edges (rr_ptr wrapped).
- Wide config: THREAD_COUNT_BITS=16, TPB=32, BLOCK_ID_BITS=11, thread_count=65535 -> 2048 blocks. The last block has id 2047 and thread count 31, and the counter has no overflow.
